instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Reader side of the program ROM. Drives the ROM address from its program counter,
//   captures the combinational read data into an output register, and hands the
//   instruction to decode over a valid/ready handshake.
//   Supports back-pressure, jump redirect, and end-of-program stop or wrap.
// PARAMETERS
//   ADDR_W  4   ROM address width; program length is 2**ADDR_W words
//   DATA_W  16  instruction width
//   WRAP    0   1: PC wraps from last address to 0; 0: stop after the last word
// PORTS
//   clk              in   1       system clock, all state on rising edge
//   rst              in   1       synchronous, active-high reset
//   start            in   1       one-cycle pulse; leaves IDLE, begins fetching at PC=0
//   rom_addr         out  ADDR_W  ROM address, always equal to the PC register
//   rom_data         in   DATA_W  ROM read data, combinational from rom_addr
//   inst_out         out  DATA_W  registered instruction to decode
//   inst_pc          out  ADDR_W  address inst_out was fetched from
//   inst_valid       out  1       inst_out/inst_pc hold a valid instruction
//   inst_ready       in   1       decode accepts inst_out this cycle
//   redirect_valid   in   1       jump request, one cycle
//   redirect_target  in   ADDR_W  jump destination
//   busy             out  1       state == RUN
//   done             out  1       state == DONE and inst_valid == 0
// BEHAVIOUR
//   - Reset: state=IDLE, pc=0, inst_out=0, inst_pc=0, inst_valid=0, busy=0, done=0.
//     Reset overrides all other inputs, including mid-RUN; the output slot is dropped.
//   - States: IDLE -start-> RUN; RUN -last word loaded and WRAP=0-> DONE;
//     any state -redirect_valid-> RUN. No other transitions; start is ignored outside IDLE.
//   - Output slot is free when inst_valid==0 or inst_ready==1.
//   - In RUN with slot free and no redirect:
//     - inst_out<=rom_data, inst_pc<=pc, inst_valid<=1.
//     - pc<=pc+1, modulo 2**ADDR_W.
//   - In RUN with slot not free: pc, inst_out, inst_pc and inst_valid hold.
//   - Throughput: 1 instruction/cycle with inst_ready held high.
//     First inst_valid appears 2 cycles after the start pulse edge (IDLE->RUN, then load).
//   - Handshake: a transfer occurs when inst_valid && inst_ready. In IDLE or DONE a
//     transfer clears inst_valid; no new load occurs.
//   - Last word (pc == 2**ADDR_W-1) loaded:
//     - WRAP=0: pc holds, state<=DONE.
//     - WRAP=1: pc<=0, state stays RUN.
//   - Redirect has priority over load and handshake in every state:
//     - pc<=redirect_target, inst_valid<=0 (in-flight instruction flushed), state<=RUN.
//     - The target word is loaded on the following cycle.
//   - Simultaneous start and redirect in IDLE: redirect wins, pc=redirect_target.
//   - rom_addr = pc at all times, combinational from the register; never X after reset.
// TESTING
//   1. Reset, then idle 5 cycles with no start:
//      -> inst_valid=0, rom_addr=0, busy=0, done=0 throughout.
//   2. ROM word0=16'h1203, word4=16'h1407; start, inst_ready=1, WRAP=0:
//      -> 16 transfers, inst_pc 0..15 in order, inst_out matches ROM (pc0=16'h1203, pc4=16'h1407).
//      -> Then done=1, busy=0, with no further inst_valid.
//   3. Back-pressure: inst_ready=0 for 3 cycles while inst_valid=1 at inst_pc=2:
//      -> inst_out/inst_pc stable, rom_addr held at 3.
//      -> After ready returns, the next transfer has inst_pc=3; no word lost or duplicated.
//   4. Redirect to 9 while inst_valid=1 at inst_pc=5:
//      -> Next cycle inst_valid=0, rom_addr=9.
//      -> Following cycle inst_pc=9; word 5 is never transferred.
//   5. WRAP=1, ready=1, run 20 cycles:
//      -> inst_pc sequence 0..15, 0..3; done never asserted.
//      -> Redirect from DONE (WRAP=0) restarts fetch at redirect_target.
//   6. Assert rst while in RUN with inst_valid=1:
//      -> Next cycle reset values exactly as in scenario 1; a later start resumes at pc 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: ROM read port, decode handshake, redirect and run control.
// master = the fetch unit, slave = the surrounding ROM/decode/control logic.
interface instruction_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              busy;
    logic              done;

    modport master (
        input  start, rom_data, inst_ready, redirect_valid, redirect_target,
        output rom_addr, inst_out, inst_pc, inst_valid, busy, done
    );

    modport slave (
        output start, rom_data, inst_ready, redirect_valid, redirect_target,
        input  rom_addr, inst_out, inst_pc, inst_valid, busy, done
    );
endinterface

// File: rtl/instruction_fetch.sv
// Program-ROM reader: PC drives the ROM address, read data is captured into a
// single output slot handed to decode over valid/ready, with jump redirect.
module instruction_fetch #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int WRAP   = 0
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic [DATA_W-1:0] inst_out_r, inst_out_nxt_s;
    logic [ADDR_W-1:0] inst_pc_r, inst_pc_nxt_s;
    logic              inst_valid_r, inst_valid_nxt_s;
    logic              busy_r, done_r;
    logic              slot_free_s, xfer_s;

    assign slot_free_s = !inst_valid_r || bus.inst_ready;
    assign xfer_s      = inst_valid_r && bus.inst_ready;

    // Next-state, PC and output-slot decision; redirect outranks everything.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        inst_out_nxt_s   = inst_out_r;
        inst_pc_nxt_s    = inst_pc_r;
        inst_valid_nxt_s = inst_valid_r;
        if (bus.redirect_valid) begin
            pc_nxt_s         = bus.redirect_target;
            inst_valid_nxt_s = 1'b0;
            state_nxt_s      = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                    if (xfer_s) begin
                        inst_valid_nxt_s = 1'b0;
                    end else begin
                        inst_valid_nxt_s = inst_valid_r;
                    end
                end
                ST_RUN: begin
                    if (slot_free_s) begin
                        inst_out_nxt_s   = bus.rom_data;
                        inst_pc_nxt_s    = pc_r;
                        inst_valid_nxt_s = 1'b1;
                        // Without wrap the PC parks on the last word once it is loaded.
                        if (pc_r == PC_LAST) begin
                            if (WRAP != 0) begin
                                pc_nxt_s = PC_ZERO;
                            end else begin
                                state_nxt_s = ST_DONE;
                            end
                        end else begin
                            pc_nxt_s = pc_r + PC_ONE;
                        end
                    end else begin
                        inst_valid_nxt_s = inst_valid_r;
                    end
                end
                ST_DONE: begin
                    if (xfer_s) begin
                        inst_valid_nxt_s = 1'b0;
                    end else begin
                        inst_valid_nxt_s = inst_valid_r;
                    end
                end
                default: begin
                    state_nxt_s      = ST_IDLE;
                    inst_valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= PC_ZERO;
            inst_out_r   <= {DATA_W{1'b0}};
            inst_pc_r    <= PC_ZERO;
            inst_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            inst_out_r   <= inst_out_nxt_s;
            inst_pc_r    <= inst_pc_nxt_s;
            inst_valid_r <= inst_valid_nxt_s;
            busy_r       <= (state_nxt_s == ST_RUN);
            done_r       <= (state_nxt_s == ST_DONE) && !inst_valid_nxt_s;
        end
    end

    assign bus.rom_addr   = pc_r;
    assign bus.inst_out   = inst_out_r;
    assign bus.inst_pc    = inst_pc_r;
    assign bus.inst_valid = inst_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a WRAP=0 instance for run/stop, back-pressure,
// redirect and reset cases, and a WRAP=1 instance for the wrap-around case.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if #(.ADDR_W(4), .DATA_W(16)) bus0 ();
    instruction_fetch_if #(.ADDR_W(4), .DATA_W(16)) bus1 ();

    instruction_fetch #(.ADDR_W(4), .DATA_W(16), .WRAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    instruction_fetch #(.ADDR_W(4), .DATA_W(16), .WRAP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [15:0] rom [16];
    assign bus0.rom_data = rom[bus0.rom_addr];
    assign bus1.rom_data = rom[bus1.rom_addr];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        start;
        logic        ready;
        logic        redir_v;
        logic [3:0]  redir_t;
        logic        exp_valid;
        logic [3:0]  exp_pc;
        logic [15:0] exp_out;
        logic [3:0]  exp_addr;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid"}, 32'(bus0.inst_valid), 32'd0);
        chk({tag, ".addr"},  32'(bus0.rom_addr),   32'd0);
        chk({tag, ".busy"},  32'(bus0.busy),       32'd0);
        chk({tag, ".done"},  32'(bus0.done),       32'd0);
    endtask

    initial begin
        int n_xfer;
        logic got_done;

        for (int k = 0; k < 16; k++) rom[k] = 16'hA000 + 16'(k);
        rom[0] = 16'h1203;
        rom[4] = 16'h1407;

        // start, ready, redir_v, redir_t | valid, pc, out, addr, busy, done
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,  16'h0000, 4'd0,  1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0,  16'h1203, 4'd1,  1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1,  16'hA001, 4'd2,  1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd2,  16'hA002, 4'd3,  1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2,  16'hA002, 4'd3,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2,  16'hA002, 4'd3,  1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2,  16'hA002, 4'd3,  1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3,  16'hA003, 4'd4,  1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd4,  16'h1407, 4'd5,  1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5,  16'hA005, 4'd6,  1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd5,  16'hA005, 4'd9,  1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd9,  16'hA009, 4'd10, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd10, 16'hA00A, 4'd11, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd11, 16'hA00B, 4'd12, 1'b1, 1'b0};

        bus0.start = 1'b0; bus0.inst_ready = 1'b0;
        bus0.redirect_valid = 1'b0; bus0.redirect_target = 4'd0;
        bus1.start = 1'b0; bus1.inst_ready = 1'b0;
        bus1.redirect_valid = 1'b0; bus1.redirect_target = 4'd0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Idle after reset, no start
        for (int i = 0; i < 5; i++) begin
            step();
            chk_reset_state($sformatf("idle%0d", i));
        end

        // Full run with WRAP=0
        bus0.start = 1'b1; bus0.inst_ready = 1'b1;
        step();
        bus0.start = 1'b0;
        n_xfer = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            step();
            if (bus0.inst_valid) begin
                chk($sformatf("run.pc%0d", n_xfer), 32'(bus0.inst_pc), 32'(n_xfer[3:0]));
                chk($sformatf("run.out%0d", n_xfer), 32'(bus0.inst_out), 32'(rom[n_xfer[3:0]]));
                n_xfer++;
            end
            if (bus0.done) got_done = 1'b1;
        end
        chk("run.count", 32'(n_xfer), 32'd16);
        chk("run.done_seen", 32'(got_done), 32'd1);
        chk("run.busy_end", 32'(bus0.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("done%0d.valid", i), 32'(bus0.inst_valid), 32'd0);
            chk($sformatf("done%0d.done", i), 32'(bus0.done), 32'd1);
        end

        // Redirect out of DONE
        bus0.redirect_valid = 1'b1; bus0.redirect_target = 4'd7;
        step();
        bus0.redirect_valid = 1'b0;
        chk("rdone.valid", 32'(bus0.inst_valid), 32'd0);
        chk("rdone.addr",  32'(bus0.rom_addr),   32'd7);
        chk("rdone.busy",  32'(bus0.busy),       32'd1);
        chk("rdone.done",  32'(bus0.done),       32'd0);
        step();
        chk("rdone.pc",    32'(bus0.inst_pc),    32'd7);
        chk("rdone.out",   32'(bus0.inst_out),   32'hA007);

        // Reset while RUN with a valid instruction held
        bus0.inst_ready = 1'b0;
        step();
        chk("prerst.valid", 32'(bus0.inst_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("rstrun");
        chk("rstrun.pc",  32'(bus0.inst_pc),  32'd0);
        chk("rstrun.out", 32'(bus0.inst_out), 32'd0);
        step();
        chk_reset_state("rstidle");
        bus0.start = 1'b1; bus0.inst_ready = 1'b1;
        step();
        bus0.start = 1'b0;
        step();
        chk("resume.valid", 32'(bus0.inst_valid), 32'd1);
        chk("resume.pc",    32'(bus0.inst_pc),    32'd0);
        chk("resume.out",   32'(bus0.inst_out),   32'h1203);

        // Back-pressure and redirect table from a fresh reset
        bus0.inst_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus0.start           = vecs[i].start;
            bus0.inst_ready      = vecs[i].ready;
            bus0.redirect_valid  = vecs[i].redir_v;
            bus0.redirect_target = vecs[i].redir_t;
            step();
            chk($sformatf("vec%0d.valid", i), 32'(bus0.inst_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.pc", i),    32'(bus0.inst_pc),    32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d.out", i),   32'(bus0.inst_out),   32'(vecs[i].exp_out));
            chk($sformatf("vec%0d.addr", i),  32'(bus0.rom_addr),   32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d.busy", i),  32'(bus0.busy),       32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d.done", i),  32'(bus0.done),       32'(vecs[i].exp_done));
        end
        bus0.start = 1'b0; bus0.redirect_valid = 1'b0;

        // WRAP=1 instance: 20 consecutive transfers
        bus1.start = 1'b1; bus1.inst_ready = 1'b1;
        step();
        bus1.start = 1'b0;
        n_xfer = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("wrap%0d.done", i), 32'(bus1.done), 32'd0);
            if (bus1.inst_valid) begin
                chk($sformatf("wrap%0d.pc", i), 32'(bus1.inst_pc), 32'(n_xfer % 16));
                n_xfer++;
            end
        end
        chk("wrap.count", 32'(n_xfer), 32'd20);
        chk("wrap.busy",  32'(bus1.busy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
